// File: rtl/fp_pkg.sv
// Shared types and constants for the FP issue slice.
// Op codes: FC_MUL, FC_DIV and FC_SQRT are only decoded on bit [2:1]. The low bit is a don't-care.
package fp_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FP_W  = 32;

    localparam logic [2:0] FC_ADD  = 3'b000;
    localparam logic [2:0] FC_SUB  = 3'b001;
    localparam logic [2:0] FC_MUL  = 3'b010;
    localparam logic [2:0] FC_DIV  = 3'b100;
    localparam logic [2:0] FC_SQRT = 3'b110;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [FP_W-1:0]  fp_word_t;

    // Every op except sqrt reads operand b.
    function automatic logic uses_b(input logic [2:0] fc);
        return ~(fc[2] & fc[1]);
    endfunction

endpackage

// File: rtl/fp_issue_unit_if.sv
// ID-to-FPU issue bus.
//   id_*  : decoded FP op from ID, with the id_ready acceptance handshake.
//   fpu_* : operands and control presented to the FPU's E1 input.
// Modports:
//   master : ID / FPU side. It drives id_*, and observes id_ready and fpu_*.
//   slave  : the issue unit.
interface fp_issue_unit_if;
    import fp_pkg::*;

    logic       id_valid;
    logic [2:0] id_fc;
    reg_idx_t   id_fs;
    reg_idx_t   id_ft;
    reg_idx_t   id_fd;
    logic       id_wf;
    logic       id_ready;

    fp_word_t   fpu_a;
    fp_word_t   fpu_b;
    logic [2:0] fpu_fc;
    logic       fpu_wf;
    reg_idx_t   fpu_fd;
    logic       fpu_ein;

    modport master (
        output id_valid, id_fc, id_fs, id_ft, id_fd, id_wf,
        input  id_ready, fpu_a, fpu_b, fpu_fc, fpu_wf, fpu_fd, fpu_ein
    );

    modport slave (
        input  id_valid, id_fc, id_fs, id_ft, id_fd, id_wf,
        output id_ready, fpu_a, fpu_b, fpu_fc, fpu_wf, fpu_fd, fpu_ein
    );

endinterface

// File: rtl/fp_regfile.sv
// 32x32 FP register file. It has two asynchronous read ports and one synchronous write port.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all entries to 0)
//   ra, rb     : read addresses
//   rda, rdb   : read data
//   we, wa, wd : write enable, address and data
module fp_regfile
    import fp_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  reg_idx_t ra,
    input  reg_idx_t rb,
    output fp_word_t rda,
    output fp_word_t rdb,
    input  logic     we,
    input  reg_idx_t wa,
    input  fp_word_t wd
);

    fp_word_t mem [2**REG_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**REG_W; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rda = mem[ra];
    assign rdb = mem[rb];

endmodule

// File: rtl/fp_issue_unit.sv
// FP issue unit. It accepts decoded FP ops from ID and issues them into the 4-stage FPU.
// It also owns the FP register file.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus              : ID op / handshake and FPU operand / control outputs
//   fpu_stall        : FPU div/sqrt stall
//   e1w..e3w, e1n..e3n, ed : FPU stage write flags, destinations and E3 result
//   ww, wn, wd       : FPU write-back port, written into the register file
//   cnt_clr          : synchronous clear of the performance counters
//   issue_cnt, raw_cnt, div_cnt : saturating counters (issues, RAW cycles, stall cycles)
module fp_issue_unit
    import fp_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_issue_unit_if.slave    bus,
    input  logic              fpu_stall,
    input  logic              e1w,
    input  logic              e2w,
    input  logic              e3w,
    input  reg_idx_t          e1n,
    input  reg_idx_t          e2n,
    input  reg_idx_t          e3n,
    input  fp_word_t          ed,
    input  logic              ww,
    input  reg_idx_t          wn,
    input  fp_word_t          wd,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  issue_cnt,
    output logic [CNT_W-1:0]  raw_cnt,
    output logic [CNT_W-1:0]  div_cnt
);

    logic     run_q;
    fp_word_t rf_a;
    fp_word_t rf_b;
    logic     raw;
    logic     issue;

    fp_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra    (bus.id_fs),
        .rb    (bus.id_ft),
        .rda   (rf_a),
        .rdb   (rf_b),
        .we    (ww),
        .wa    (wn),
        .wd    (wd)
    );

    // Results in E1/E2 are not computed yet and cannot be forwarded.
    function automatic logic pending(input reg_idx_t r);
        return (e1w && (e1n == r)) || (e2w && (e2n == r));
    endfunction

    // E3 is the younger producer, so it wins over WB.
    function automatic fp_word_t fwd(input reg_idx_t r, input fp_word_t rf_val);
        if (e3w && (e3n == r)) return ed;
        if (ww && (wn == r))   return wd;
        return rf_val;
    endfunction

    // The flag rises on the first edge after reset. It keeps the FPU enabled so the pipeline drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    assign raw = bus.id_valid &
                 (pending(bus.id_fs) | (uses_b(bus.id_fc) & pending(bus.id_ft)));

    assign bus.id_ready = run_q & ~fpu_stall & ~raw;
    assign issue        = bus.id_valid & bus.id_ready;

    always_comb begin
        bus.fpu_a   = fwd(bus.id_fs, rf_a);
        bus.fpu_b   = fwd(bus.id_ft, rf_b);
        bus.fpu_ein = run_q;
        // Bubbles carry fc=add so the FPU never starts a spurious div/sqrt.
        bus.fpu_fc  = FC_ADD;
        bus.fpu_wf  = 1'b0;
        bus.fpu_fd  = '0;
        if (issue) begin
            bus.fpu_fc = bus.id_fc;
            bus.fpu_wf = bus.id_wf;
            bus.fpu_fd = bus.id_fd;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != '1)) ? c + 1'b1 : c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            raw_cnt   <= '0;
            div_cnt   <= '0;
        end else if (cnt_clr) begin
            issue_cnt <= '0;
            raw_cnt   <= '0;
            div_cnt   <= '0;
        end else begin
            issue_cnt <= sat_inc(issue_cnt, issue);
            raw_cnt   <= sat_inc(raw_cnt, raw & ~fpu_stall);
            div_cnt   <= sat_inc(div_cnt, bus.id_valid & fpu_stall);
        end
    end

endmodule

// File: doc/fp_issue_unit.md
Name: fp_issue_unit

Overview:
- Upstream end of the FPU interface: accepts decoded FP ops from ID and issues them into the 4-stage FPU (E1, E2, E3, WB), driving the FPU's a, b, fc, wf, fd and ein inputs.
- Owns the 32x32 FP register file, written from the FPU write-back outputs.
- Consumes the FPU stage status (e1w..e3w, e1n..e3n, ww, wn, ed, wd, stall) for RAW interlock and operand forwarding.
- The FPU pipeline advances only when ein=1 and stall=0, so this block drives ein every cycle and inserts bubbles itself.

Parameters:
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
id_valid  in  1  ID holds a valid FP op
id_fc  in  3  op code: 000 add, 001 sub, 01x mul, 10x div, 11x sqrt
id_fs  in  5  source reg a
id_ft  in  5  source reg b (unused for sqrt)
id_fd  in  5  destination reg
id_wf  in  1  op writes the FP regfile
id_ready  out  1  op accepted this cycle; ID advances only when id_valid & id_ready
fpu_a  out  32  operand a to the FPU
fpu_b  out  32  operand b to the FPU
fpu_fc  out  3  op code to the FPU
fpu_wf  out  1  write flag to the FPU
fpu_fd  out  5  destination to the FPU
fpu_ein  out  1  enable to the FPU
fpu_stall  in  1  FPU div/sqrt stall
e1w,e2w,e3w  in  1 each  stage write flags
e1n,e2n,e3n  in  5 each  stage destination numbers
ed  in  32  E3 result
ww  in  1  WB write enable
wn  in  5  WB destination
wd  in  32  WB result
cnt_clr  in  1  synchronous clear of the counters
issue_cnt  out  CNT_W  ops issued
raw_cnt  out  CNT_W  cycles lost to RAW interlock
div_cnt  out  CNT_W  cycles lost to fpu_stall

Behaviour:
Reset:
- run=0, regfile all 0, counters 0.
- Reset values: fpu_ein=0, id_ready=0, fpu_wf=0, fpu_fc=000, fpu_fd=0, fpu_a=fpu_b=0.

Run flag:
- run sets to 1 on the first clk edge after reset release and stays 1.
- fpu_ein = run. It is held at 1 even with no op pending, so the pipeline drains.

Operand use:
- use_a=1 for every op.
- use_b = ~id_fc[2] | ~id_fc[1], i.e. 0 only for sqrt.

RAW interlock:
- raw = id_valid & (use_a & hit1/2(id_fs) | use_b & hit1/2(id_ft)).
- hit1/2(r) = (e1w & e1n==r) | (e2w & e2n==r).
- These results do not exist yet, so the op must wait.

Accept and issue:
- id_ready = run & ~fpu_stall & ~raw.
- issue = id_valid & id_ready.

Outputs to the FPU:
- On issue: fpu_fc=id_fc, fpu_wf=id_wf, fpu_fd=id_fd.
- Otherwise a bubble: fpu_fc=000, fpu_wf=0, fpu_fd=0. Forcing fc=000 on bubbles is mandatory so no spurious div/sqrt starts.
- All fpu_* outputs are combinational from the ID inputs and current state; the FPU registers them.

Operand forwarding, per source r (highest priority first):
- e3w & e3n==r -> ed
- ww & wn==r -> wd
- otherwise regfile[r]
- A register may be matched by both E3 and WB; E3, the younger producer, wins.
- fpu_a and fpu_b are driven with forwarded values even on bubble cycles; the FPU ignores them.

Write-back:
- regfile[wn] <= wd on every clk edge where ww=1.
- This is unconditional and idempotent while the FPU is stalled with WB held.

fpu_stall:
- While fpu_stall=1: id_ready=0 and nothing issues.
- On fpu_stall falling, the held op is re-evaluated in the same cycle.

Counters:
- All three saturate at all-ones and do not wrap.
- cnt_clr has priority over increments.
- issue_cnt += issue.
- raw_cnt += id_valid & raw & ~fpu_stall.
- div_cnt += id_valid & fpu_stall.

Back-to-back dependent ops:
- add f3 after add f3 sees e1 hit -> 2 bubble cycles, then forwards from ed.

Reset mid-operation:
- Asynchronous clear of all state. In-flight FPU ops are discarded by the FPU's own reset.

Decomposition:
- Package fp_pkg: FC_ADD=3'b000, FC_SUB=3'b001, FC_MUL=3'b01x, FC_DIV=3'b10x, FC_SQRT=3'b11x; REG_W=5; FP_W=32.
- Sub-module fp_regfile: 32x32 storage, two async read ports, one sync write port, asynchronous reset to 0.
- Forwarding muxes and interlock stay in fp_issue_unit.

Test Plan:
1. Reset, then one cycle after release: fpu_ein=1, id_ready=1; with id_valid=0, fpu_fc=000, fpu_wf=0, regfile reads 0.
2. Preload f1=0x3F800000 and f2=0x40000000 via ops. Issue add f3,f1,f2 -> one cycle with fpu_a=0x3F800000, fpu_b=0x40000000, fpu_fc=000, fpu_wf=1, fpu_fd=3, issue_cnt+1.
3. add f3,f1,f2 then add f4,f3,f1 -> id_ready=0 for 2 cycles (raw_cnt+=2); third cycle issues with fpu_a=ed=0x40400000 via E3 forward.
4. Op reading f3 when only WB holds it (ww=1, wn=3, wd=0x40400000) -> fpu_a=0x40400000; next cycle regfile[3]=0x40400000.
5. E3 (e3n=5, ed=0x41000000) and WB (wn=5, wd=0x40000000) both match f5 -> fpu_a=0x41000000.
6. Div issued, fpu_stall=1 for 20 cycles with id_valid=1 -> id_ready=0, bubble fc=000, div_cnt=20. Sqrt f6,f7 while e1n=f6's ft and e1w=1 (ft unused by sqrt) -> no RAW stall. Counter preloaded to 0xFFFF stays 0xFFFF on increment.
